// File: rtl/pawc_pkg.sv
// pawc_pkg: register map, STATUS bit positions and sequencer states shared by the phase-shifter SPI block.
package pawc_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0, REG_STATUS = 2'd1, REG_TXDATA = 2'd2, REG_LOAD = 2'd3;
  localparam int ST_BUSY = 0, ST_EMPTY = 1, ST_FULL = 2, ST_OVF = 3, ST_LVL = 8;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LATCH} state_t;
endpackage

// File: rtl/pawc_sync_fifo.sv
// pawc_sync_fifo: single-clock FIFO with level output; pushes while full and pops while empty are ignored.
module pawc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/wb_phase_spi.sv
// wb_phase_spi: Wishbone-fed SPI serialiser that streams queued phase words to a shifter chain and pulses its latch.
module wb_phase_spi
  import pawc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_rty_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  output logic        spi_ld_o
);
  localparam int BW = $clog2(FRAME_BITS) + 1;
  state_t state, state_n;
  logic [7:0] clkdiv, cnt, div;
  logic enable, overflow, load_pending, ack, phase, half_end, dispatch, start, pop, push, busy, framing, last;
  logic [BW-1:0] bits;
  logic [FRAME_BITS-1:0] sh, fifo_dout;
  logic fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic [1:0] a;
  logic req, wr, unused;
  logic [31:0] status, rdata;
  assign unused = ^{wb_sel_i, wb_adr_i, wb_dat_i};
  assign a = wb_adr_i[3:2];
  assign req = wb_cyc_i & wb_stb_i & !ack;
  assign wr = req & wb_we_i;
  assign push = wr && a == REG_TXDATA;
  pawc_sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(push), .pop(pop), .din(wb_dat_i[FRAME_BITS-1:0]),
    .dout(fifo_dout), .empty(fifo_empty), .full(fifo_full), .level(level)
  );
  // GAP expiry makes the same start decision as IDLE so back-to-back frames keep exactly H cycles of cs_n high.
  assign half_end = cnt == div;
  assign dispatch = state == IDLE || (state == GAP && half_end);
  assign start = enable & !fifo_empty;
  assign pop = dispatch & start;
  assign last = bits == BW'(FRAME_BITS - 1);
  always_comb begin
    state_n = dispatch ? (start ? SETUP : (enable & fifo_empty & load_pending) ? LATCH : IDLE)
            : !half_end ? state
            : state == SETUP ? SHIFT
            : state == SHIFT ? ((!phase && last) ? HOLD : SHIFT)
            : state == HOLD ? GAP
            : state == LATCH ? (phase ? LATCH : IDLE)
            : state;
  end
  // div is reloaded only at half-period boundaries so a clkdiv write never stretches a half already running.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      div <= '0;
      phase <= 1'b0;
      bits <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || half_end) ? 8'd0 : cnt + 8'd1;
      if (state_n != state || half_end) div <= clkdiv;
      phase <= (state_n != state) ? 1'b1 : half_end ? !phase : phase;
      bits <= (state != SHIFT) ? '0 : (half_end && !phase) ? bits + BW'(1) : bits;
      if (pop) sh <= fifo_dout;
      else if (state == SHIFT && half_end && phase) sh <= sh << 1;
    end
  end
  assign busy = state != IDLE || load_pending;
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL] = fifo_full;
    status[ST_OVF] = overflow;
    status[ST_LVL +: 8] = 8'(level);
    rdata = a == REG_CTRL ? {23'd0, enable, clkdiv} : a == REG_STATUS ? status : '0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack <= 1'b0;
      wb_dat_o <= '0;
      clkdiv <= '0;
      enable <= 1'b0;
      overflow <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      ack <= req;
      wb_dat_o <= (req & !wb_we_i) ? rdata : '0;
      if (wr && a == REG_CTRL) {enable, clkdiv} <= wb_dat_i[8:0];
      if (wr && a == REG_STATUS && wb_dat_i[ST_OVF]) overflow <= 1'b0;
      else if (push && fifo_full) overflow <= 1'b1;
      if (wr && a == REG_LOAD) load_pending <= 1'b1;
      else if (state == LATCH && state_n == IDLE) load_pending <= 1'b0;
    end
  end
  assign framing = state == SETUP || state == SHIFT || state == HOLD;
  assign wb_ack_o = ack;
  assign wb_rty_o = 1'b0;
  assign spi_sclk_o = state == SHIFT && phase;
  assign spi_cs_n_o = !framing;
  assign spi_mosi_o = framing & sh[FRAME_BITS-1];
  assign spi_ld_o = state == LATCH;
endmodule

// File: tb/tb_wb_phase_spi.sv
// tb_wb_phase_spi: random-word bench; an SPI monitor reconstructs frames, cs_n/gap/latch lengths for comparison with spec timing.
module tb_wb_phase_spi;
  localparam int FB = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat_i = '0, dat_o;
  logic [3:0] sel = 4'hf;
  logic we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, rty, sclk, mosi, cs_n, ld;
  int vectors = 0, miscompares = 0;
  logic [FB-1:0] frames[$];
  int lens[$], nrises[$], gaps[$], lds[$];
  logic [FB-1:0] cur = '0;
  int len = 0, rises = 0, hi = 0, ld_len = 0;
  logic sclk_p = 1'b0, cs_p = 1'b1;

  always #5 clk = ~clk;

  wb_phase_spi #(.FIFO_DEPTH(8), .FRAME_BITS(FB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_rty_o(rty), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n), .spi_ld_o(ld)
  );

  // Observes the SPI pins as a slave would: sample MOSI on SCLK rise, measure cs_n low/high runs and latch pulses.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      cur = '0; len = 0; rises = 0; hi = 0; ld_len = 0; sclk_p = 1'b0; cs_p = 1'b1;
    end else begin
      if (!cs_n) begin
        if (cs_p) gaps.push_back(hi);
        len++;
        if (sclk && !sclk_p) begin cur = {cur[FB-2:0], mosi}; rises++; end
      end else begin
        if (!cs_p) begin
          frames.push_back(cur); lens.push_back(len); nrises.push_back(rises);
          cur = '0; len = 0; rises = 0; hi = 0;
        end
        hi++;
      end
      if (ld) ld_len++;
      else if (ld_len != 0) begin lds.push_back(ld_len); ld_len = 0; end
      sclk_p = sclk;
      cs_p = cs_n;
    end
  end

  task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a}; dat_i = d;
    @(posedge clk); #1;
    vectors++;
    if (ack !== 1'b1 || rty !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_on_time adr=%h: ack=%b rty=%b, required ack=1 rty=0", a, ack, rty);
    end
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_single adr=%h: ack=%b, required 0", a, ack);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ld(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (lds.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cs_n, sclk, mosi, ld, ack, rty} !== 6'b100000 || dat_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: cs_n,sclk,mosi,ld,ack,rty=%b dat_o=%h, required 100000 and 0", {cs_n, sclk, mosi, ld, ack, rty}, dat_o);
    end
    rst = 1'b0;
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h2) begin miscompares++; $display("FAIL reset_status: got %h, required 00000002", r); end
    wb(1'b0, 4'h0, 0, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h, required 0", r); end
    wb(1'b0, 4'h8, 0, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL read_txdata: got %h, required 0", r); end
    wb(1'b0, 4'hC, 0, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL read_load: got %h, required 0", r); end
  endtask

  task automatic test_frame;
    logic [31:0] r;
    logic [FB-1:0] w;
    int base, h;
    bit ok;
    for (int k = 0; k < 5; k++) begin
      h = (k == 0) ? 1 : int'($urandom_range(1, 4));
      w = (k == 0) ? 16'hA5C3 : 16'($urandom);
      base = frames.size();
      wb(1'b1, 4'h0, 32'h100 | 32'(h - 1), r);
      wb(1'b1, 4'h8, 32'(w), r);
      wait_frames(base + 1, 34 * h + 60, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL frame_timeout k=%0d: no frame, required one", k); end
      else begin
        vectors++;
        if (frames[base] !== w) begin miscompares++; $display("FAIL frame_bits k=%0d: got %h, required %h", k, frames[base], w); end
        vectors++;
        if (lens[base] != 34 * h) begin miscompares++; $display("FAIL frame_cs_len k=%0d: got %0d, required %0d", k, lens[base], 34 * h); end
        vectors++;
        if (nrises[base] != FB) begin miscompares++; $display("FAIL frame_rises k=%0d: got %0d, required %0d", k, nrises[base], FB); end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_load;
    logic [31:0] r;
    logic [FB-1:0] w[3];
    int base, gbase, lbase;
    bit ok;
    base = frames.size(); gbase = gaps.size(); lbase = lds.size();
    wb(1'b1, 4'h0, 32'h103, r);
    for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); wb(1'b1, 4'h8, 32'(w[i]), r); end
    wb(1'b1, 4'hC, 32'h1, r);
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r[0] !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b, required 1", r[0]); end
    wait_ld(lbase + 1, 2000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL load_timeout: no latch pulse, required one"); end
    else begin
      vectors++;
      if (frames.size() != base + 3) begin miscompares++; $display("FAIL load_order: %0d frames before latch, required 3", frames.size() - base); end
      else for (int i = 0; i < 3; i++) begin
        vectors++;
        if (frames[base+i] !== w[i] || lens[base+i] != 136) begin
          miscompares++;
          $display("FAIL load_frame%0d: got %h len %0d, required %h len 136", i, frames[base+i], lens[base+i], w[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (gaps[gbase+i] != 4) begin miscompares++; $display("FAIL load_gap%0d: got %0d, required 4", i, gaps[gbase+i]); end
      end
      vectors++;
      if (lds[lbase] != 8) begin miscompares++; $display("FAIL load_ld_len: got %0d, required 8", lds[lbase]); end
    end
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h2) begin miscompares++; $display("FAIL load_status_after: got %h, required 00000002", r); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic [FB-1:0] w[9];
    int base;
    bit ok;
    wb(1'b1, 4'h0, 32'h0, r);
    base = frames.size();
    for (int i = 0; i < 9; i++) begin w[i] = 16'($urandom); wb(1'b1, 4'h8, 32'(w[i]), r); end
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h080C) begin miscompares++; $display("FAIL ovf_status: got %h, required 0000080c", r); end
    wb(1'b1, 4'h4, 32'h8, r);
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h0804) begin miscompares++; $display("FAIL ovf_clear: got %h, required 00000804", r); end
    wb(1'b1, 4'h0, 32'h100, r);
    wait_frames(base + 8, 1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovf_drain_timeout: got %0d frames, required 8", frames.size() - base); end
    else for (int i = 0; i < 8; i++) begin
      vectors++;
      if (frames[base+i] !== w[i]) begin miscompares++; $display("FAIL ovf_frame%0d: got %h, required %h", i, frames[base+i], w[i]); end
    end
    repeat (100) @(negedge clk);
    vectors++;
    if (frames.size() != base + 8) begin miscompares++; $display("FAIL ovf_ninth: got %0d frames, required 8", frames.size() - base); end
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h2) begin miscompares++; $display("FAIL ovf_status_end: got %h, required 00000002", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int base;
    bit ok;
    wb(1'b1, 4'h0, 32'h0, r);
    wb(1'b1, 4'h8, 32'($urandom), r);
    wb(1'b1, 4'h8, 32'($urandom), r);
    base = frames.size();
    wb(1'b1, 4'h0, 32'h101, r);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rises >= 5) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_timeout: rises=%0d, required 5", rises); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({cs_n, sclk, mosi} !== 3'b100) begin miscompares++; $display("FAIL rstmid_async: cs_n,sclk,mosi=%b, required 100", {cs_n, sclk, mosi}); end
    @(posedge clk); #1;
    rst = 1'b0;
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h2) begin miscompares++; $display("FAIL rstmid_status: got %h, required 00000002", r); end
    wb(1'b0, 4'h0, 0, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL rstmid_ctrl: got %h, required 0", r); end
    repeat (50) @(negedge clk);
    vectors++;
    if (frames.size() != base) begin miscompares++; $display("FAIL rstmid_partial: got %0d frames, required 0", frames.size() - base); end
  endtask

  task automatic test_enable_clear;
    logic [31:0] r;
    logic [FB-1:0] w1, w2;
    int base;
    bit ok;
    w1 = 16'($urandom); w2 = 16'($urandom);
    base = frames.size();
    wb(1'b1, 4'h0, 32'h0, r);
    wb(1'b1, 4'h8, 32'(w1), r);
    wb(1'b1, 4'h8, 32'(w2), r);
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h0200) begin miscompares++; $display("FAIL en_status_pre: got %h, required 00000200", r); end
    wb(1'b1, 4'h0, 32'h101, r);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises >= 3) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL en_timeout: rises=%0d, required 3", rises); end
    wb(1'b1, 4'h0, 32'h001, r);
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h0101) begin miscompares++; $display("FAIL en_status_mid: got %h, required 00000101", r); end
    wait_frames(base + 1, 300, ok);
    vectors++;
    if (!ok || frames[base] !== w1 || lens[base] != 68) begin
      miscompares++;
      $display("FAIL en_frame: seen=%b got %h, required %h len 68", ok, ok ? frames[base] : 16'h0, w1);
    end
    repeat (80) @(negedge clk);
    vectors++;
    if (frames.size() != base + 1) begin miscompares++; $display("FAIL en_no_new: got %0d frames, required 1", frames.size() - base); end
    wb(1'b0, 4'h4, 0, r);
    vectors++;
    if (r !== 32'h0100) begin miscompares++; $display("FAIL en_status_post: got %h, required 00000100", r); end
    wb(1'b1, 4'h0, 32'h100, r);
    wait_frames(base + 2, 200, ok);
    vectors++;
    if (!ok || frames[base+1] !== w2) begin miscompares++; $display("FAIL en_resume: seen=%b, required frame %h", ok, w2); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_load();
    test_overflow();
    test_reset_mid();
    test_enable_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
